cpu_spm_rmw: RTL and testbench

- Bus-side access adapter placed directly upstream of the scratch-pad memory (SPM) port B.
- Accepts word or byte-enable requests through a valid/ready handshake and drives the word-only SPM port B.
- Byte-masked writes are done as read-modify-write (RMW) sequences.
- Returns read data and write completions as a one-cycle response pulse.

---
 rtl/cpu_spm_rmw_if.sv | 28 ++
 rtl/cpu_spm_rmw.sv | 122 ++++++++++++
 tb/tb_cpu_spm_rmw.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_spm_rmw_if.sv
// Request/response bundle between a bus master and the SPM RMW adapter.
// The adapter is the slave; response has no backpressure.
interface cpu_spm_rmw_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    localparam int BE_W  = DATA_W / 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [BE_W-1:0]   req_be;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr,
        output req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr,
        input  req_be, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/cpu_spm_rmw.sv
// Byte-enable to word-only SPM port B adapter using read-modify-write.
// Define SPM_RMW_FAST_WR_EN to send full-word writes straight through WR.
module cpu_spm_rmw #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    cpu_spm_rmw_if.slave      bus,
    output logic [ADDR_W-1:0] spm_addr,
    output logic [DATA_W-1:0] spm_wdata,
    output logic              spm_we,
    input  logic [DATA_W-1:0] spm_rdata
);

`ifdef SPM_RMW_FAST_WR_EN
    typedef enum logic [2:0] {
        IDLE, RD, MRG, RSP, WR
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE, RD, MRG, RSP
    } state_t;
`endif

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [DATA_W-1:0] merged;
    logic              rsp_fire;
    logic              accept;

    assign accept        = (state_q == IDLE) && bus.req_valid;
    assign spm_addr      = addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_comb begin
        merged = '0;
        for (int i = 0; i < BE_W; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8]
                                       : spm_rdata[8*i +: 8];
        end
    end

    // Fast writes raise the pulse on leaving WR; RSP is only turnaround.
`ifdef SPM_RMW_FAST_WR_EN
    assign rsp_fire = (state_q == WR) ||
                      ((state_q == RSP) && !(we_q && (&be_q)));
`else
    assign rsp_fire = (state_q == RSP);
`endif

    always_comb begin
        state_d       = state_q;
        spm_we        = 1'b0;
        spm_wdata     = '0;
        bus.req_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = RD;
`ifdef SPM_RMW_FAST_WR_EN
                    if (bus.req_we && (&bus.req_be)) begin
                        state_d = WR;
                    end
`endif
                end
            end
            RD: state_d = MRG;
            MRG: begin
                if (we_q && (|be_q)) begin
                    spm_we    = 1'b1;
                    spm_wdata = merged;
                end
                state_d = RSP;
            end
            RSP: state_d = IDLE;
`ifdef SPM_RMW_FAST_WR_EN
            WR: begin
                spm_we    = 1'b1;
                spm_wdata = wdata_q;
                state_d   = RSP;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_fire;
            if (accept) begin
                addr_q      <= bus.req_addr;
                be_q        <= bus.req_be;
                wdata_q     <= bus.req_wdata;
                we_q        <= bus.req_we;
                rsp_rdata_q <= '0;
            end
            if (state_q == MRG) begin
                rsp_rdata_q <= we_q ? '0 : spm_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cpu_spm_rmw.sv
// Directed bench for cpu_spm_rmw with a registered-read SPM model.
// Honours SPM_RMW_FAST_WR_EN for the full-word write latency.
module tb_cpu_spm_rmw;

    logic        clk;
    logic        reset;
    logic [11:0] spm_addr;
    logic [31:0] spm_wdata;
    logic        spm_we;
    logic [31:0] spm_rdata;

    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;
    logic [31:0] mem [4096];

    int checks;
    int errors;

    cpu_spm_rmw_if #(.DATA_W(32), .ADDR_W(12)) bus ();

    cpu_spm_rmw #(.DATA_W(32), .ADDR_W(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .spm_addr  (spm_addr),
        .spm_wdata (spm_wdata),
        .spm_we    (spm_we),
        .spm_rdata (spm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (spm_we) mem[spm_addr] <= spm_wdata;
        spm_rdata <= mem[spm_addr];
    end

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        pl;
        logic [31:0] plv;
        logic [31:0] exp_rd;
        logic [31:0] exp_word;
        int          exp_wes;
        int          exp_lat;
        int          exp_weidx;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a,
                           input logic [31:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic run(input vec_t v,
                       output logic [31:0] rd,
                       output int lat,
                       output int pulses,
                       output int wes,
                       output int weidx);
        rd = '0; lat = -1; pulses = 0; wes = 0; weidx = -1;
        @(negedge clk);
        bus.req_we    = v.we;
        bus.req_addr  = v.addr;
        bus.req_be    = v.be;
        bus.req_wdata = v.wdata;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = 32'h0BAD_0BAD;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (spm_we) begin
                wes++;
                if (weidx < 0) weidx = k - 1;
            end
            if (bus.rsp_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k - 1;
                    rd  = bus.rsp_rdata;
                end
            end
        end
    endtask

    logic [31:0] rd;
    int lat, pulses, wes, weidx;
    int fast_lat, fast_idx;
    int acc [3];
    logic [31:0] got [4];
    int n, ng, cnt;
    logic [31:0] bb_addr [3];

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; pl_en = 1'b0;
        pl_addr = '0; pl_data = '0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0;
        bus.req_addr = '0; bus.req_be = '0;
        bus.req_wdata = '0;
`ifdef SPM_RMW_FAST_WR_EN
        fast_lat = 1; fast_idx = 0;
`else
        fast_lat = 3; fast_idx = 1;
`endif
        tv[0] = '{1'b0, 12'h010, 4'h0, 32'h0,
                  1'b1, 32'hDEADBEEF,
                  32'hDEADBEEF, 32'hDEADBEEF, 0, 3, -1};
        tv[1] = '{1'b1, 12'h020, 4'b0101, 32'h11223344,
                  1'b1, 32'hAABBCCDD,
                  32'h0, 32'hAA22CC44, 1, 3, 1};
        tv[2] = '{1'b0, 12'h020, 4'hF, 32'h0,
                  1'b0, 32'h0,
                  32'hAA22CC44, 32'hAA22CC44, 0, 3, -1};
        tv[3] = '{1'b1, 12'h021, 4'b0000, 32'hFFFFFFFF,
                  1'b1, 32'h12345678,
                  32'h0, 32'h12345678, 0, 3, -1};
        tv[4] = '{1'b1, 12'h022, 4'b1010, 32'h11223344,
                  1'b1, 32'hAABBCCDD,
                  32'h0, 32'h11BB33DD, 1, 3, 1};
        tv[5] = '{1'b1, 12'h040, 4'hF, 32'hCAFEF00D,
                  1'b1, 32'h0,
                  32'h0, 32'hCAFEF00D, 1, fast_lat, fast_idx};
        tv[6] = '{1'b0, 12'h040, 4'h0, 32'h0,
                  1'b0, 32'h0,
                  32'hCAFEF00D, 32'hCAFEF00D, 0, 3, -1};
        tv[7] = '{1'b1, 12'hFFF, 4'b1000, 32'h5A000000,
                  1'b1, 32'h0,
                  32'h0, 32'h5A000000, 1, 3, 1};

        #1;
        chk("rst_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_spm_we", {31'b0, spm_we}, 32'd0);
        chk("rst_spm_addr", {20'b0, spm_addr}, 32'd0);
        chk("rst_spm_wdata", spm_wdata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            if (tv[i].pl) preload(tv[i].addr, tv[i].plv);
            run(tv[i], rd, lat, pulses, wes, weidx);
            chk($sformatf("v%0d_rdata", i), rd, tv[i].exp_rd);
            chk($sformatf("v%0d_lat", i), lat, tv[i].exp_lat);
            chk($sformatf("v%0d_pulses", i), pulses, 32'd1);
            chk($sformatf("v%0d_we_cnt", i), wes, tv[i].exp_wes);
            if (tv[i].exp_wes == 1)
                chk($sformatf("v%0d_we_idx", i), weidx,
                    tv[i].exp_weidx);
            chk($sformatf("v%0d_word", i), mem[tv[i].addr],
                tv[i].exp_word);
        end

        // Back-to-back reads with req_valid held high
        bb_addr[0] = 32'h010; bb_addr[1] = 32'h020;
        bb_addr[2] = 32'h040;
        n = 0; ng = 0;
        @(negedge clk);
        bus.req_we    = 1'b0;
        bus.req_be    = 4'h0;
        bus.req_addr  = bb_addr[0][11:0];
        bus.req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus.rsp_valid && ng < 4) begin
                got[ng] = bus.rsp_rdata;
                ng++;
            end
            if (bus.req_ready && bus.req_valid) begin
                if (n < 3) acc[n] = c;
                n++;
            end else if (!bus.req_ready) begin
                if (n < 3) bus.req_addr = bb_addr[n][11:0];
                else bus.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk("b2b_accepts", n, 32'd3);
        chk("b2b_rsp_cnt", ng, 32'd3);
        if (n >= 3) begin
            chk("b2b_gap01", acc[1] - acc[0], 32'd4);
            chk("b2b_gap12", acc[2] - acc[1], 32'd4);
        end
        if (ng >= 3) begin
            chk("b2b_rd0", got[0], 32'hDEADBEEF);
            chk("b2b_rd1", got[1], 32'hAA22CC44);
            chk("b2b_rd2", got[2], 32'hCAFEF00D);
        end

        // Reset while the write sits in MRG
        preload(12'h030, 32'h0BADF00D);
        @(negedge clk);
        bus.req_we    = 1'b1;
        bus.req_addr  = 12'h030;
        bus.req_be    = 4'b0011;
        bus.req_wdata = 32'hFFFFFFFF;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mrg_we_before_rst", {31'b0, spm_we}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mrg_we_after_rst", {31'b0, spm_we}, 32'd0);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) cnt++;
        end
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) cnt++;
        end
        chk("mrg_rst_no_rsp", cnt, 32'd0);
        chk("mrg_rst_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("mrg_rst_word", mem[12'h030], 32'h0BADF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
